rf68000_nic_master: RTL and testbench

RF68000_NIC_MASTER -- requirements
Module: rf68000_nic_master

---
 rtl/rf68000_nic_pkg.sv | 15 +
 rtl/rf68000_nic_master.sv | 159 +++++++++++++++
 tb/tb_rf68000_nic_master.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rf68000_nic_pkg.sv
// Shared types and constants for the rf68000 NIC Wishbone burst master.
package rf68000_nic_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_REQ,
        ST_ACKLOW,
        ST_DELIVER,
        ST_END
    } state_t;

    localparam logic [7:0] TIMEOUT_DEFAULT = 8'd255;

endpackage

// File: rtl/rf68000_nic_master.sv
// Burst Wishbone initiator: moves cmd_len words between the stream ports and the
// node arbiter NIC port, holding cyc_o for the whole burst.
module rf68000_nic_master
    import rf68000_nic_pkg::*;
#(
    parameter logic [7:0] TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [7:0]  cmd_len,
    input  logic        wd_valid,
    output logic        wd_ready,
    input  logic [31:0] wd_data,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic [31:0] rd_data,
    output logic        cyc_o,
    output logic        stb_o,
    output logic        we_o,
    output logic [3:0]  sel_o,
    output logic [31:0] adr_o,
    output logic [31:0] dat_o,
    input  logic        ack_i,
    input  logic [31:0] dat_i,
    output logic        done,
    output logic        err
);

    state_t      state;
    logic        we_lat;
    logic [29:0] word_adr;
    logic [7:0]  count;
    logic [7:0]  timer;
    logic        advance;

    always_comb begin
        cmd_ready = (state == ST_IDLE);
        wd_ready  = (state == ST_FETCH);
        rd_valid  = (state == ST_DELIVER);
        // A word is fully retired: write after ack fell, or read once consumed.
        advance   = ((state == ST_ACKLOW) && !ack_i && we_lat) ||
                    ((state == ST_DELIVER) && rd_ready);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            we_lat   <= 1'b0;
            word_adr <= '0;
            count    <= '0;
            timer    <= '0;
            cyc_o    <= 1'b0;
            stb_o    <= 1'b0;
            we_o     <= 1'b0;
            sel_o    <= '0;
            adr_o    <= '0;
            dat_o    <= '0;
            rd_data  <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (state == ST_REQ) timer <= timer + 8'd1;
            else                 timer <= '0;

            if (advance) begin
                if (count == 8'd0) begin
                    state <= ST_END;
                    cyc_o <= 1'b0;
                    done  <= 1'b1;
                end else if (we_lat) begin
                    state <= ST_FETCH;
                end else begin
                    state <= ST_REQ;
                    stb_o <= 1'b1;
                    we_o  <= 1'b0;
                    sel_o <= 4'hF;
                    adr_o <= {word_adr, 2'b00};
                    dat_o <= '0;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        we_lat   <= cmd_we;
                        word_adr <= cmd_adr[31:2];
                        count    <= cmd_len;
                        if (cmd_len == 8'd0) begin
                            state <= ST_END;
                            done  <= 1'b1;
                        end else begin
                            cyc_o <= 1'b1;
                            if (cmd_we) begin
                                state <= ST_FETCH;
                            end else begin
                                state <= ST_REQ;
                                stb_o <= 1'b1;
                                we_o  <= 1'b0;
                                sel_o <= 4'hF;
                                adr_o <= {cmd_adr[31:2], 2'b00};
                                dat_o <= '0;
                            end
                        end
                    end
                end
                ST_FETCH: begin
                    if (wd_valid) begin
                        state <= ST_REQ;
                        stb_o <= 1'b1;
                        we_o  <= 1'b1;
                        sel_o <= 4'hF;
                        adr_o <= {word_adr, 2'b00};
                        dat_o <= wd_data;
                    end
                end
                ST_REQ: begin
                    if (ack_i) begin
                        state    <= ST_ACKLOW;
                        stb_o    <= 1'b0;
                        we_o     <= 1'b0;
                        sel_o    <= '0;
                        dat_o    <= '0;
                        word_adr <= word_adr + 30'd1;
                        count    <= count - 8'd1;
                        if (!we_lat) rd_data <= dat_i;
                    end else if (timer == TIMEOUT - 8'd1) begin
                        // Give up on the burst entirely and release the arbiter.
                        state <= ST_IDLE;
                        cyc_o <= 1'b0;
                        stb_o <= 1'b0;
                        we_o  <= 1'b0;
                        sel_o <= '0;
                        dat_o <= '0;
                        err   <= 1'b1;
                        done  <= 1'b1;
                    end
                end
                ST_ACKLOW: begin
                    if (!ack_i && !we_lat) state <= ST_DELIVER;
                end
                ST_DELIVER: begin
                end
                ST_END: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rf68000_nic_master.sv
// Directed bench for rf68000_nic_master with a small Wishbone arbiter/RAM model.
module tb_rf68000_nic_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_adr;
    logic [7:0]  cmd_len;
    logic        wd_valid, wd_ready;
    logic [31:0] wd_data;
    logic        rd_valid, rd_ready;
    logic [31:0] rd_data;
    logic        cyc_o, stb_o, we_o;
    logic [3:0]  sel_o;
    logic [31:0] adr_o, dat_o;
    logic        ack_i = 1'b0;
    logic [31:0] dat_i;
    logic        done, err;

    int checks = 0;
    int errors = 0;

    rf68000_nic_master dut (
        .clk_i(clk), .rst_i(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_len(cmd_len),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .sel_o(sel_o),
        .adr_o(adr_o), .dat_o(dat_o), .ack_i(ack_i), .dat_i(dat_i),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Arbiter model: acks after ack_delay strobe cycles, holds ack until strobe falls.
    logic [31:0] mem [0:15];
    int          ack_delay = 3;
    bit          ack_en = 1'b1;
    int          wait_cnt = 0;
    logic [31:0] wr_dat_seen = '0;
    int          wr_count = 0;

    always @(posedge clk) begin
        if (!(cyc_o && stb_o)) begin
            ack_i    <= 1'b0;
            wait_cnt <= 0;
        end else if (ack_en && !ack_i) begin
            if (wait_cnt == ack_delay - 1) begin
                ack_i <= 1'b1;
                if (we_o) begin
                    wr_dat_seen <= dat_o;
                    wr_count    <= wr_count + 1;
                end
            end
            wait_cnt <= wait_cnt + 1;
        end
    end

    assign dat_i = mem[adr_o[5:2]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [7:0]  len;
        logic [31:0] wd_base;
        int          exp_strobes;
        logic [31:0] exp_last_adr;
        logic [31:0] exp_last_data;
    } vec_t;

    vec_t vecs [5];

    task automatic run_vec(input vec_t v);
        int strobes = 0, cycles = 0, cyc_drop = 0, cyc_hi = 0, wd_idx = 0, rd_words = 0;
        logic prev_stb = 1'b0;
        logic seen_done = 1'b0;
        logic [31:0] last_adr = '0, last_data = '0, ea, base;
        base = {v.adr[31:2], 2'b00};
        chk("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
        cmd_we = v.we; cmd_adr = v.adr; cmd_len = v.len; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        while (!seen_done && cycles < 2000) begin
            if (cyc_o) cyc_hi++;
            if (stb_o && !prev_stb) begin
                ea = base + 32'(strobes * 4);
                chk("adr_step", adr_o, ea);
                chk("sel_full", {28'd0, sel_o}, 32'hF);
                chk("we_match", {31'd0, we_o}, {31'd0, v.we});
                chk("dat_o_word", dat_o, v.we ? v.wd_base + 32'(strobes) : 32'd0);
                last_adr = adr_o;
                strobes++;
            end
            if (!stb_o) chk("dat_o_idle", dat_o, 32'd0);
            if (rd_valid) begin
                ea = base + 32'(rd_words * 4);
                chk("rd_word", rd_data, mem[ea[5:2]]);
                last_data = rd_data;
                rd_words++;
            end
            if (done) begin
                seen_done = 1'b1;
                chk("done_cyc_low", {31'd0, cyc_o}, 32'd0);
                chk("done_no_err", {31'd0, err}, 32'd0);
            end else if (!cyc_o && v.len != 8'd0) begin
                cyc_drop++;
            end
            prev_stb = stb_o;
            wd_valid = wd_ready;
            wd_data  = v.wd_base + 32'(wd_idx);
            if (wd_ready) wd_idx++;
            rd_ready = 1'b1;
            if (!seen_done) begin
                @(posedge clk); #1;
                cycles++;
            end
        end
        chk("done_seen", {31'd0, seen_done}, 32'd1);
        chk("strobe_count", strobes, v.exp_strobes);
        chk("cyc_held", cyc_drop, 0);
        if (v.len == 8'd0) begin
            chk("len0_no_cyc", cyc_hi, 0);
        end else begin
            chk("last_adr", last_adr, v.exp_last_adr);
            chk("last_data", v.we ? wr_dat_seen : last_data, v.exp_last_data);
        end
        @(posedge clk); #1;
        chk("done_pulse_one", {31'd0, done}, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, cycles;
        for (int i = 0; i < 16; i++) mem[i] = 32'(i + 1);
        vecs[0] = '{1'b1, 32'hFFF00010, 8'd1, 32'hDEADBEEF, 1, 32'hFFF00010, 32'hDEADBEEF};
        vecs[1] = '{1'b0, 32'hFFF00000, 8'd4, 32'h0,        4, 32'hFFF0000C, 32'h4};
        vecs[2] = '{1'b0, 32'hFFFFFFFC, 8'd2, 32'h0,        2, 32'h00000000, 32'h1};
        vecs[3] = '{1'b0, 32'h00001000, 8'd0, 32'h0,        0, 32'h0,        32'h0};
        vecs[4] = '{1'b1, 32'h00000100, 8'd3, 32'h11110000, 3, 32'h00000108, 32'h11110002};

        rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_len = '0;
        wd_valid = 1'b0; wd_data = '0; rd_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cyc", {31'd0, cyc_o}, 32'd0);
        chk("rst_stb", {31'd0, stb_o}, 32'd0);
        chk("rst_adr", adr_o, 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_done_err", {30'd0, done, err}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_ready", {31'd0, cmd_ready}, 32'd1);
        chk("post_rst_quiet", {28'd0, cyc_o, stb_o, done, err}, 32'd0);

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Read consumer stalls: no second strobe until the first word is taken.
        rd_ready = 1'b0;
        cmd_we = 1'b0; cmd_adr = 32'hFFF00000; cmd_len = 8'd2; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cycles = 0;
        while (!rd_valid && cycles < 100) begin @(posedge clk); #1; cycles++; end
        chk("stall_rd_valid", {31'd0, rd_valid}, 32'd1);
        chk("stall_first_word", rd_data, 32'd1);
        n = 0;
        for (int i = 0; i < 10; i++) begin @(posedge clk); #1; if (stb_o) n++; end
        chk("stall_no_strobe", n, 0);
        chk("stall_hold_valid", {31'd0, rd_valid}, 32'd1);
        chk("stall_cyc_held", {31'd0, cyc_o}, 32'd1);
        rd_ready = 1'b1;
        n = 0; cycles = 0;
        while (!done && cycles < 100) begin
            @(posedge clk); #1; cycles++;
            if (stb_o && ack_i) n++;
        end
        chk("stall_done", {31'd0, done}, 32'd1);
        chk("stall_second_strobe", n, 1);
        chk("stall_second_word", rd_data, 32'd2);
        @(posedge clk); #1;

        // No ack at all: timeout after exactly TIMEOUT cycles of strobe.
        ack_en = 1'b0;
        cmd_we = 1'b0; cmd_adr = 32'h00000040; cmd_len = 8'd3; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        n = 0; cycles = 0;
        while (!err && cycles < 1000) begin
            if (stb_o) n++;
            @(posedge clk); #1; cycles++;
        end
        chk("timeout_err", {31'd0, err}, 32'd1);
        chk("timeout_req_cycles", n, 255);
        chk("timeout_done", {31'd0, done}, 32'd1);
        chk("timeout_bus_idle", {30'd0, cyc_o, stb_o}, 32'd0);
        @(posedge clk); #1;
        chk("timeout_pulse_one", {30'd0, err, done}, 32'd0);
        chk("timeout_idle", {30'd0, cmd_ready, cyc_o}, 32'h2);
        ack_en = 1'b1;

        // Asynchronous reset in the middle of a strobe.
        ack_delay = 20;
        cmd_we = 1'b0; cmd_adr = 32'hFFF00000; cmd_len = 8'd4; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("midrst_in_req", {30'd0, cyc_o, stb_o}, 32'h3);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_bus_drop", {30'd0, cyc_o, stb_o}, 32'd0);
        chk("midrst_adr_clear", adr_o, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (cyc_o || stb_o || done || err) n++;
        end
        chk("midrst_no_stale", n, 0);
        chk("midrst_ready", {31'd0, cmd_ready}, 32'd1);
        ack_delay = 3;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
